// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers an upstream payload, then streams
// header, payload and XOR parity to the router with busy back-pressure.
module router_pkt_tx (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic [5:0] pkt_len,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_active,
  output logic       done,
  output logic       addr_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] header_q, header_d;
  logic [7:0] parity_q, parity_d;
  logic [7:0] data_out_q, data_out_d;
  logic [5:0] count_q, count_d;
  logic [5:0] idx_q, idx_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       addr_err_q, addr_err_d;
  logic       done_q, done_d;
  logic       pl_ready_q, pl_ready_d;
  logic       tx_active_q, tx_active_d;
  logic       buf_we;
  logic [5:0] len;
  logic [7:0] buf_mem [64];

  assign len = header_q[7:2];

  always_comb begin
    state_d     = state_q;
    header_d    = header_q;
    parity_d    = parity_q;
    count_d     = count_q;
    idx_d       = idx_q;
    data_out_d  = data_out_q;
    pkt_valid_d = pkt_valid_q;
    addr_err_d  = 1'b0;
    buf_we      = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        if (dest_addr == 2'd3 || pkt_len == 6'd0) begin
          addr_err_d = 1'b1;
        end else begin
          header_d = {pkt_len, dest_addr};
          parity_d = {pkt_len, dest_addr};
          count_d  = 6'd0;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: if (pl_valid) begin
        buf_we   = 1'b1;
        parity_d = parity_q ^ pl_data;
        count_d  = count_q + 6'd1;
        if (count_q == len - 6'd1) begin
          data_out_d  = header_q;
          pkt_valid_d = 1'b1;
          state_d     = S_HEADER;
        end
      end
      S_HEADER: if (!busy) begin
        data_out_d  = buf_mem[0];
        pkt_valid_d = 1'b1;
        idx_d       = 6'd0;
        state_d     = S_PAYLOAD;
      end
      S_PAYLOAD: if (!busy) begin
        // parity_q is final here: the last payload byte was folded in during LOAD
        if (idx_q == len - 6'd1) begin
          data_out_d  = parity_q;
          pkt_valid_d = 1'b0;
          state_d     = S_PARITY;
        end else begin
          idx_d      = idx_q + 6'd1;
          data_out_d = buf_mem[idx_q + 6'd1];
        end
      end
      S_PARITY: if (!busy) begin
        data_out_d  = 8'h00;
        pkt_valid_d = 1'b0;
        state_d     = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    pl_ready_d  = (state_d == S_LOAD);
    tx_active_d = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      header_q    <= 8'h00;
      parity_q    <= 8'h00;
      data_out_q  <= 8'h00;
      count_q     <= 6'd0;
      idx_q       <= 6'd0;
      pkt_valid_q <= 1'b0;
      addr_err_q  <= 1'b0;
      done_q      <= 1'b0;
      pl_ready_q  <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      parity_q    <= parity_d;
      data_out_q  <= data_out_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      pkt_valid_q <= pkt_valid_d;
      addr_err_q  <= addr_err_d;
      done_q      <= done_d;
      pl_ready_q  <= pl_ready_d;
      tx_active_q <= tx_active_d;
    end
  end

  // Payload storage needs no reset; it is always written before being read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[count_q] <= pl_data;
  end

  assign pl_ready  = pl_ready_q;
  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign tx_active = tx_active_q;
  assign done      = done_q;
  assign addr_err  = addr_err_q;

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 Parameters: none; widths are fixed by the router packet format (header = {len[5:0], addr[1:0]}, 1..63 payload bytes, 1 parity byte).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; one clock domain only.
REQ-004 start  input  1  request to send one packet, sampled only in IDLE.
REQ-005 dest_addr  input  2  destination port 0..2; value 3 is illegal.
REQ-006 pkt_len  input  6  payload byte count 1..63; 0 is illegal.
REQ-007 pl_data  input  8  payload byte from the upstream source.
REQ-008 pl_valid  input  1  pl_data is valid.
REQ-009 pl_ready  output  1  block accepts a payload byte this cycle.
REQ-010 busy  input  1  router stall; the current byte is not consumed while high.
REQ-011 data_out  output  8  byte to router data_in.
REQ-012 pkt_valid  output  1  high with header and payload bytes, low with the parity byte.
REQ-013 tx_active  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle pulse after the parity byte is consumed.
REQ-015 addr_err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 FSM states: IDLE, LOAD, HEADER, PAYLOAD, PARITY, DONE.
REQ-017 IDLE: start=1 with dest_addr!=3 and pkt_len!=0 shall latch header={pkt_len,dest_addr}, clear the byte counter, set parity=header, and move to LOAD.
REQ-018 IDLE: start=1 with dest_addr=3 or pkt_len=0 shall pulse addr_err for one cycle and remain in IDLE.
REQ-019 start outside IDLE shall be ignored.
REQ-020 LOAD: pl_ready=1. Each edge with pl_valid=1 writes pl_data into a 64x8 internal buffer at index count, XORs the byte into parity, and increments count.
REQ-021 LOAD: the edge accepting byte pkt_len-1 shall move to HEADER. pl_valid gaps shall stall LOAD with no side effects.
REQ-022 pl_ready shall be 0 in every state except LOAD.
REQ-023 data_out and pkt_valid shall be registered. They are loaded on the edge that enters HEADER, PAYLOAD or PARITY, or that advances the PAYLOAD index.
REQ-024 A presented byte is consumed on any rising edge where busy=0. While busy=1, data_out, pkt_valid, state and index shall hold.
REQ-025 HEADER presents data_out=header with pkt_valid=1. On consumption, the block presents buffer[0] and enters PAYLOAD.
REQ-026 PAYLOAD presents buffer[i] with pkt_valid=1, i=0..pkt_len-1.
REQ-027 After buffer[pkt_len-1] is consumed, the block presents data_out=parity with pkt_valid=0 and enters PARITY.
REQ-028 PARITY: on consumption, the block drives pkt_valid=0 and data_out=0 and enters DONE.
REQ-029 DONE: done=1 for exactly one cycle, then return to IDLE. A start in the DONE cycle is ignored.
REQ-030 parity is the 8-bit XOR of the header and all payload bytes. It matches the router's internal parity, so a correct transfer yields router error=0.
REQ-031 pkt_len=1 shall produce exactly 3 bytes on data_out: header, payload, parity. pkt_len=63 shall use buffer indices 0..62 with no wrap.
REQ-032 busy changing to 0 in the same cycle a state is entered shall consume the byte on the next edge. Consumption is never skipped and never doubled.
REQ-033 Outside HEADER/PAYLOAD/PARITY, pkt_valid=0 and data_out=0.

Reset
REQ-034 reset=0 at any time, including mid-packet, shall immediately force state=IDLE and count=0.
REQ-035 It shall force pkt_valid=0, data_out=0x00, pl_ready=0, tx_active=0, done=0 and addr_err=0.
REQ-036 It shall also clear header and parity to 0x00. Buffer contents need not be cleared.
REQ-037 After reset is released, the first start is accepted normally.

Verification
REQ-038 Scenario: addr=1, len=3, payload 11,22,33, busy=0 -> data_out 0D(pv=1), 11, 22, 33(pv=1), 0D(pv=0), then done pulse; router error=0.
REQ-039 Scenario: same packet with busy=1 for 4 cycles during byte 22 -> 22 is held 5 cycles; stream order and parity 0D are unchanged; no duplicated byte.
REQ-040 Scenario: start with addr=3 and, separately, len=0 -> addr_err pulse 1 cycle each; tx_active stays 0; pkt_valid stays 0.
REQ-041 Scenario: len=63, payload 0..62 with random pl_valid gaps -> 65 bytes out.
  - Parity = 0xFD ^ XOR(0..62) = 0xFD ^ 0x3F = 0xC2.
  - pkt_valid falls only on the last byte.
REQ-042 Scenario: reset asserted during PAYLOAD byte 2 of len=5 -> all outputs 0 at once; after release, a new addr=2, len=1 packet sends 06, payload, parity correctly.
REQ-043 Scenario: start pulses during LOAD and during DONE -> ignored; no second packet is sent.
